ifu_axi_fetch: RTL and testbench

- Parametrised instruction-fetch AXI4-Lite read master; successor to the single-request fetch front-end.
- Accepts fetch requests over a valid/ready interface and keeps up to OSTD reads in flight on AR/R.
- Returns in-order responses tagged with their address and error status.
- Supports pipeline flush (branch/trap redirect): in-flight responses are discarded without violating AXI handshake rules.

---
 rtl/ifu_axi_fetch.sv | 217 +++++++++++++++++++++
 tb/tb_ifu_axi_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch AXI4-Lite read master: keeps up to OSTD reads in flight and drains them on flush.
// Define IFU_FETCH_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt/perf_flush_drop_cnt counters.
module ifu_axi_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OSTD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [ADDR_W-1:0]   resp_addr,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_drop_cnt
`endif
);

  localparam int LSB   = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(OSTD + 1);
  localparam int PTR_W = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam logic [CNT_W:0] OSTD_L = (CNT_W + 1)'(OSTD);

  logic [CNT_W-1:0]  ostd_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic              arvalid_r;
  logic [ADDR_W-1:0] araddr_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_data_r;
  logic [ADDR_W-1:0] resp_addr_r;
  logic              resp_err_r;
  logic [ADDR_W-1:0] fifo_r [OSTD];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;

  logic [CNT_W:0]    inflight_s;
  logic              dropping_s;
  logic              req_ready_s;
  logic              rready_s;
  logic              req_hs_s;
  logic              ar_hs_s;
  logic              r_hs_s;
  logic              deliver_s;
  logic [ADDR_W-1:0] req_aligned_s;
  logic              unused_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OSTD - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1'b1);
    end
  endfunction

  assign req_aligned_s = {req_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
  assign unused_s      = ^{awready, wready, bvalid, bresp, req_addr[LSB-1:0]};

  // Ready terms; in-flight count includes an AR still waiting for arready so the FIFO cannot overflow
  always_comb begin
    inflight_s  = {1'b0, ostd_cnt_r} + {{CNT_W{1'b0}}, arvalid_r};
    dropping_s  = (drop_cnt_r != {CNT_W{1'b0}});
    req_ready_s = 1'b0;
    rready_s    = 1'b0;
    if (rst) begin
      req_ready_s = 1'b0;
      rready_s    = 1'b0;
    end else begin
      req_ready_s = !flush && (!arvalid_r || arready) && (inflight_s < OSTD_L);
      rready_s    = dropping_s || !resp_valid_r || resp_ready;
    end
  end

  assign req_hs_s  = req_valid && req_ready_s;
  assign ar_hs_s   = arvalid_r && arready;
  assign r_hs_s    = rvalid && rready_s;
  assign deliver_s = r_hs_s && !dropping_s && !flush;

  // AR channel register: held until arready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_r <= 1'b0;
      araddr_r  <= {ADDR_W{1'b0}};
    end else if (req_hs_s) begin
      arvalid_r <= 1'b1;
      araddr_r  <= req_aligned_s;
    end else if (arready) begin
      arvalid_r <= 1'b0;
    end
  end

  // Outstanding AR count and number of pre-flush beats still to discard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ostd_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({ar_hs_s, r_hs_s})
        2'b10:   ostd_cnt_r <= ostd_cnt_r + CNT_W'(1'b1);
        2'b01:   ostd_cnt_r <= ostd_cnt_r - CNT_W'(1'b1);
        default: ostd_cnt_r <= ostd_cnt_r;
      endcase
      if (flush) begin
        drop_cnt_r <= inflight_s[CNT_W-1:0] - CNT_W'(r_hs_s);
      end else if (r_hs_s && dropping_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_W'(1'b1);
      end
    end
  end

  // In-flight address FIFO: push on request accept, pop on every R beat (kept or dropped)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < OSTD; i++) begin
        fifo_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      if (req_hs_s) begin
        fifo_r[wr_ptr_r] <= req_aligned_s;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (r_hs_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Response output register; a beat arriving during flush is consumed but never presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      resp_addr_r  <= {ADDR_W{1'b0}};
      resp_err_r   <= 1'b0;
    end else if (flush) begin
      resp_valid_r <= 1'b0;
    end else if (deliver_s) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= rdata;
      resp_addr_r  <= fifo_r[rd_ptr_r];
      resp_err_r   <= (rresp != 2'b00);
    end else if (resp_ready) begin
      resp_valid_r <= 1'b0;
    end
  end

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_stall_r;
  logic [31:0] perf_drop_r;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_r <= 32'd0;
      perf_stall_r <= 32'd0;
      perf_drop_r  <= 32'd0;
    end else begin
      if (deliver_s) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (req_valid && !req_ready_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (r_hs_s && !deliver_s) begin
        perf_drop_r <= perf_drop_r + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt      = perf_fetch_r;
  assign perf_stall_cnt      = perf_stall_r;
  assign perf_flush_drop_cnt = perf_drop_r;
`endif

  assign req_ready  = req_ready_s;
  assign rready     = rready_s;
  assign arvalid    = arvalid_r;
  assign araddr     = araddr_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_addr  = resp_addr_r;
  assign resp_err   = resp_err_r;
  assign awaddr     = {ADDR_W{1'b0}};
  assign awvalid    = 1'b0;
  assign wdata      = {DATA_W{1'b0}};
  assign wstrb      = {(DATA_W/8){1'b0}};
  assign wvalid     = 1'b0;
  assign bready     = 1'b0;

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Randomized scoreboard bench for ifu_axi_fetch with a randomized AXI4-Lite read slave.
module tb_ifu_axi_fetch;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OSTD   = 2;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, flush;
  logic [ADDR_W-1:0] req_addr;
  logic resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_addr;
  logic [ADDR_W-1:0] awaddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0] bresp;
  logic [ADDR_W-1:0] araddr;
  logic arvalid, arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_drop_cnt;
`endif

  ifu_axi_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OSTD(OSTD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_addr(resp_addr), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef IFU_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_drop_cnt(perf_flush_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } ar_t;

  exp_t exp_q[$];
  ar_t  ar_q[$];
  int vectors = 0;
  int miscompares = 0;
  int ar_pct = 100;
  int max_lat = 1;
  int inflight = 0;
  int pres_cnt = 0;
  int stall_cnt = 0;
  int rhs_cnt = 0;

  int kn_req[4] = '{90, 80, 70, 90};
  int kn_rr[4]  = '{100, 50, 70, 30};
  int kn_fl[4]  = '{0, 0, 8, 5};
  int kn_ar[4]  = '{100, 50, 60, 30};
  int kn_lat[4] = '{1, 6, 5, 3};

  // Slave memory image: data and response code are fixed functions of the aligned address
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    case (a[5:2])
      4'd3:    return 2'b10;
      4'd9:    return 2'b11;
      4'd12:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One stimulus cycle: record accepted requests/flushes, then drive the next inputs
  task automatic stim_cycle(input int req_pct, input int rr_pct, input int fl_pct);
    logic acc, fl;
    logic [31:0] a;
    exp_t e;
    @(negedge clk);
    acc = !rst && req_valid && req_ready;
    fl  = !rst && flush;
    if (acc) begin
      a = req_addr & ~32'h0000_0003;
      e.addr = a;
      e.data = mem_data(a);
      e.err  = (mem_resp(a) != 2'b00);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    if (!req_valid || acc) begin
      req_valid = ($urandom_range(99) < req_pct);
      req_addr  = 32'h8000_0000 | ($urandom() & 32'h0000_03FF);
    end
    resp_ready = ($urandom_range(99) < rr_pct);
    flush = !fl && ($urandom_range(99) < fl_pct);
  endtask

  // AXI read slave: in-order responses after a random latency, random arready
  initial begin : slave
    logic ar_fire, r_fire;
    logic [31:0] a;
    ar_t t;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_fire = !rst && arvalid && arready;
      r_fire  = !rst && rvalid && rready;
      a = araddr;
      @(posedge clk);
      #1;
      if (rst) begin
        ar_q.delete();
        rvalid = 1'b0;
        arready = 1'b0;
      end else begin
        if (ar_fire) begin
          t.addr = a;
          t.due = cyc + $urandom_range(max_lat, 0);
          ar_q.push_back(t);
        end
        if (r_fire) rvalid = 1'b0;
        if (!rvalid && ar_q.size() > 0 && cyc >= ar_q[0].due) begin
          t = ar_q.pop_front();
          rvalid = 1'b1;
          rdata = mem_data(t.addr);
          rresp = mem_resp(t.addr);
        end
        arready = ($urandom_range(99) < ar_pct);
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake and checks protocol rules
  initial begin : monitor
    logic hold_v, hold_ar, h_err;
    logic [31:0] h_addr, h_data, h_araddr;
    exp_t e;
    hold_v = 1'b0; hold_ar = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0; hold_ar = 1'b0;
        inflight = 0; pres_cnt = 0; stall_cnt = 0; rhs_cnt = 0;
      end else begin
        check("wr_chan_idle", {awvalid, wvalid, bready, |awaddr, |wdata, |wstrb}, 96'd0);
        if (hold_v) check("resp_hold", {resp_valid, resp_err, resp_addr, resp_data}, {1'b1, h_err, h_addr, h_data});
        if (hold_ar) check("ar_hold", {arvalid, araddr}, {1'b1, h_araddr});
        if (arvalid) check("ar_align", araddr[1:0], 2'b00);
        if (!resp_valid) check("rready_when_empty", rready, 1'b1);
        if (resp_valid && !hold_v) pres_cnt++;
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got addr 0x%0h, want no response (cycle %0d)", resp_addr, cyc);
          end else begin
            e = exp_q.pop_front();
            check("resp_addr", resp_addr, e.addr);
            check("resp_data", resp_data, e.data);
            check("resp_err", resp_err, e.err);
          end
        end
        if (arvalid && arready) begin
          inflight++;
          check("ostd_limit", (inflight > OSTD), 1'b0);
        end
        if (rvalid && rready) begin
          inflight--;
          rhs_cnt++;
        end
        if (req_valid && !req_ready) stall_cnt++;
        hold_v = resp_valid && !resp_ready && !flush;
        h_err = resp_err; h_addr = resp_addr; h_data = resp_data;
        hold_ar = arvalid && !arready;
        h_araddr = araddr;
      end
    end
  end

  initial begin : main
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0; resp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready}, 96'd0);
    check("reset_data", {araddr, resp_addr, resp_data}, 96'd0);
    rst = 1'b0;

    for (int ph = 0; ph < 4; ph++) begin
      ar_pct = kn_ar[ph];
      max_lat = kn_lat[ph];
      for (int i = 0; i < 300; i++) stim_cycle(kn_req[ph], kn_rr[ph], kn_fl[ph]);
    end

    // Reset while an AR is pending: everything must drop to zero at once and stay quiet
    ar_pct = 0;
    for (int n = 0; n < 60 && !arvalid; n++) stim_cycle(100, 100, 0);
    check("ar_pending_before_reset", arvalid, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_ctrl", {req_ready, resp_valid, arvalid, rready, resp_err}, 96'd0);
    check("async_reset_data", {araddr, resp_addr, resp_data}, 96'd0);
    exp_q.delete();
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ar_pct = 100;
    for (int i = 0; i < 30; i++) stim_cycle(0, 100, 0);
    check("no_ar_after_reset", arvalid, 1'b0);

    ar_pct = 70;
    max_lat = 4;
    for (int i = 0; i < 300; i++) stim_cycle(85, 60, 6);

    for (int n = 0; n < 400; n++) begin
      if (exp_q.size() == 0 && !resp_valid && !rvalid && !arvalid && ar_q.size() == 0 && !req_valid) break;
      stim_cycle(0, 100, 0);
    end
    check("drain_complete", {exp_q.size(), 31'd0, resp_valid, rvalid, arvalid, req_valid}, 96'd0);
`ifdef IFU_FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, pres_cnt);
    check("perf_drop", perf_flush_drop_cnt, rhs_cnt - pres_cnt);
    check("perf_stall", perf_stall_cnt, stall_cnt);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
